instr_fetch_unit: RTL

Parametrised instruction fetch stage with a prefetch queue, branch redirect and halt control. It generates the program counter, issues reads to a synchronous instruction memory with one-cycle read latency, and buffers returned instructions with their PCs. It presents them to decode over a valid/ready handshake. It is the front stage of the pipeline and the successor of the single-register PC fetch stage.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_prefetch_queue.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and the
// prefetch queue entry. Entry field widths set the fetch unit's ADDR_W/INSTR_W.
package if_pkg;

    localparam int IF_ADDR_W  = 8;
    localparam int IF_INSTR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_prefetch_queue.sv
// Circular FIFO holding fetched {pc, instr} pairs; flush beats push, and the
// head reads as zero while the queue is empty.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  if_entry_t                push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output if_entry_t                head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, one-cycle-latency imem requests, in-flight
// tracking and prefetch queue. IF_PERF_CNT_EN adds FetchCount/FlushCount.
//
// state  | meaning
// IDLE   | one settling cycle after reset, no requests
// FETCH  | issuing requests while queue credit allows
// HALTED | no new requests; queue keeps draining
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                INSTR_W  = IF_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Redirect,
    input  logic [ADDR_W-1:0]   RedirectPC,
    input  logic                Halt,
    output logic                ImemReq,
    output logic [ADDR_W-1:0]   ImemAddr,
    input  logic [INSTR_W-1:0]  ImemRdata,
    output logic                IfValid,
    input  logic                IfReady,
    output logic [INSTR_W-1:0]  IfInstr,
    output logic [ADDR_W-1:0]   IfPC
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]         FetchCount,
    output logic [15:0]         FlushCount
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if_state_t           state;
    if_state_t           state_next;
    logic [ADDR_W-1:0]   fetch_pc;
    logic                inflight;
    logic [ADDR_W-1:0]   inflight_pc;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    occupied;
    logic                has_credit;
    logic                push;
    logic                pop;
    if_entry_t           push_data;
    if_entry_t           head;

    // Reserve a slot for the outstanding response so the queue cannot overflow.
    assign occupied   = count + CNT_W'(inflight);
    assign has_credit = occupied < CNT_W'(DEPTH);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ImemReq    = 1'b0;
        IfValid    = 1'b0;
        case (state)
            IDLE:    state_next = Halt ? HALTED : FETCH;
            FETCH:   if (Halt)  state_next = HALTED;
            HALTED:  if (!Halt) state_next = FETCH;
            default: state_next = IDLE;
        endcase
        if (Redirect) begin
            state_next = state;
        end
        ImemReq = (state == FETCH) && !Halt && !Redirect && has_credit;
        IfValid = (count != '0) && !Redirect;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (Redirect) begin
            fetch_pc <= RedirectPC;
            inflight <= 1'b0;
        end else begin
            inflight <= ImemReq;
            if (ImemReq) begin
                fetch_pc    <= fetch_pc + PC_STEP;
                inflight_pc <= fetch_pc;
            end
        end
    end

    // A response landing in a redirect cycle belongs to the old path: drop it.
    assign push            = inflight && !Redirect;
    assign pop             = IfValid && IfReady;
    assign push_data.pc    = inflight_pc;
    assign push_data.instr = ImemRdata;

    if_prefetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (Clk),
        .rst       (Reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (Redirect),
        .count     (count),
        .head      (head)
    );

    assign ImemAddr = fetch_pc;
    assign IfInstr  = head.instr;
    assign IfPC     = head.pc;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            if (pop && (FetchCount != 16'hFFFF)) begin
                FetchCount <= FetchCount + 16'd1;
            end
            if (Redirect && (FlushCount != 16'hFFFF)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end
`endif

endmodule
